// File: rtl/layer_pkg.sv
// Shared constants and types for the layer-1 to layer-2 node-value link.
// Both the layer-1 transmit side and the layer-2 controller import this
// package, so frame geometry and handshake state encoding stay in one place.
package layer_pkg;

    localparam int NUM_NODES = 4;    // node values per frame
    localparam int NODE_W    = 6;    // quantised node width
    localparam int L2_IN_W   = 24;   // packed frame width (NUM_NODES*NODE_W)
    localparam int SUM_W     = 16;   // signed accumulator width
    localparam int SHIFT     = 4;    // right shift applied before saturation

    // Transmit-side handshake states
    typedef enum logic [1:0] {
        TX_IDLE         = 2'd0,
        TX_WAIT_ACK     = 2'd1,
        TX_WAIT_RELEASE = 2'd2
    } tx_state_t;

endpackage

// File: rtl/relu_quantize.sv
// relu_quantize: combinational ReLU + scale + saturate of one accumulator sum.
// Ports:
//   sum  in  SUM_W   signed accumulator value
//   q    out NODE_W  0 for sum <= 0, else min(sum >>> SHIFT, 2^NODE_W-1)
module relu_quantize #(
    parameter int SUM_W  = 16,
    parameter int NODE_W = 6,
    parameter int SHIFT  = 4
) (
    input  logic signed [SUM_W-1:0]  sum,
    input  logic                     unused_tie,
    output logic        [NODE_W-1:0] q
);

    localparam logic [SUM_W-1:0] Q_MAX = SUM_W'((1 << NODE_W) - 1);

    logic [SUM_W-1:0] shifted_s;
    logic             non_pos_s;

    // Scale the sum; only used when it is strictly positive, so the
    // arithmetic shift result is non-negative and can be compared unsigned.
    always_comb begin
        shifted_s = SUM_W'(sum >>> SHIFT);
        non_pos_s = sum[SUM_W-1] | (sum == SUM_W'(0)) | (unused_tie & 1'b0);
    end

    // ReLU then saturate to the node width
    always_comb begin
        q = {NODE_W{1'b0}};
        if (non_pos_s) begin
            q = {NODE_W{1'b0}};
        end else if (shifted_s > Q_MAX) begin
            q = {NODE_W{1'b1}};
        end else begin
            q = shifted_s[NODE_W-1:0];
        end
    end

endmodule

// File: rtl/layer1_output_sender.sv
// layer1_output_sender: collects quantised layer-1 node values into a fill
// buffer and sends complete frames to layer-2 over a 4-phase handshake.
// A separate transmit register lets the next frame fill while the current
// one is in handshake.
// Ports:
//   clk            in  1      rising-edge clock
//   reset          in  1      synchronous active-high reset
//   nodeValid      in  1      nodeSum/nodeIndex valid
//   nodeIndex      in  2      node slot
//   nodeSum        in  SUM_W  signed layer-1 sum
//   nodeReady      out 1      fill buffer can accept a node
//   layer2Input    out 24     packed frame, node i at [6i+5:6i]
//   inputsReady    out 1      frame valid request to layer-2
//   inputsRecieved in  1      layer-2 acknowledge
//   framesSent     out 8      completed handshakes (wraps)
//   dupError       out 1      sticky: a slot was written twice in one frame
module layer1_output_sender #(
    parameter int NUM_NODES = layer_pkg::NUM_NODES,
    parameter int NODE_W    = layer_pkg::NODE_W,
    parameter int SUM_W     = layer_pkg::SUM_W,
    parameter int SHIFT     = layer_pkg::SHIFT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    nodeValid,
    input  logic [1:0]              nodeIndex,
    input  logic signed [SUM_W-1:0] nodeSum,
    output logic                    nodeReady,
    output logic [23:0]             layer2Input,
    output logic                    inputsReady,
    input  logic                    inputsRecieved,
    output logic [7:0]              framesSent,
    output logic                    dupError
);

    import layer_pkg::*;

    localparam int FRAME_W = NUM_NODES * NODE_W;

    tx_state_t          state_r;
    logic [NODE_W-1:0]  fill_val_r [NUM_NODES];
    logic [NUM_NODES-1:0] mask_r;
    logic               dup_r;
    logic [FRAME_W-1:0] tx_frame_r;
    logic               ready_r;
    logic [7:0]         frames_r;

    logic               fill_full_s;
    logic               accept_s;
    logic               load_s;
    logic [NODE_W-1:0]  q_s;
    logic [FRAME_W-1:0] fill_pack_s;

    relu_quantize #(
        .SUM_W  (SUM_W),
        .NODE_W (NODE_W),
        .SHIFT  (SHIFT)
    ) u_quant (
        .sum        (nodeSum),
        .unused_tie (1'b0),
        .q          (q_s)
    );

    assign fill_full_s = &mask_r;
    // Never accept while full: this also keeps a node write and a frame
    // transfer from landing in the same cycle.
    assign accept_s    = nodeValid & ~fill_full_s;

    assign nodeReady   = ~fill_full_s;
    assign layer2Input = tx_frame_r;
    assign inputsReady = ready_r;
    assign framesSent  = frames_r;
    assign dupError    = dup_r;

    // Decide whether the fill buffer moves into the transmit register this cycle
    always_comb begin
        load_s = 1'b0;
        case (state_r)
            TX_IDLE:         load_s = fill_full_s;
            TX_WAIT_RELEASE: load_s = fill_full_s & ~inputsRecieved;
            default:         load_s = 1'b0;
        endcase
    end

    // Pack fill-buffer slots into frame layout, slot 0 in the low bits
    always_comb begin
        fill_pack_s = {FRAME_W{1'b0}};
        for (int i = 0; i < NUM_NODES; i++) begin
            fill_pack_s[i*NODE_W +: NODE_W] = fill_val_r[i];
        end
    end

    // Fill buffer, valid mask and sticky duplicate-write flag
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_r <= {NUM_NODES{1'b0}};
            dup_r  <= 1'b0;
            for (int i = 0; i < NUM_NODES; i++) begin
                fill_val_r[i] <= {NODE_W{1'b0}};
            end
        end else if (load_s) begin
            mask_r <= {NUM_NODES{1'b0}};
        end else if (accept_s) begin
            fill_val_r[nodeIndex] <= q_s;
            mask_r[nodeIndex]     <= 1'b1;
            if (mask_r[nodeIndex]) begin
                dup_r <= 1'b1;
            end
        end
    end

    // Transmit FSM with registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= TX_IDLE;
            ready_r    <= 1'b0;
            tx_frame_r <= {FRAME_W{1'b0}};
            frames_r   <= 8'd0;
        end else begin
            case (state_r)
                TX_IDLE: begin
                    // A stray acknowledge here is ignored
                    if (load_s) begin
                        tx_frame_r <= fill_pack_s;
                        ready_r    <= 1'b1;
                        state_r    <= TX_WAIT_ACK;
                    end
                end
                TX_WAIT_ACK: begin
                    if (inputsRecieved) begin
                        ready_r  <= 1'b0;
                        frames_r <= frames_r + 8'd1;
                        state_r  <= TX_WAIT_RELEASE;
                    end
                end
                TX_WAIT_RELEASE: begin
                    if (!inputsRecieved) begin
                        // Chain straight into the next frame if one is waiting
                        if (load_s) begin
                            tx_frame_r <= fill_pack_s;
                            ready_r    <= 1'b1;
                            state_r    <= TX_WAIT_ACK;
                        end else begin
                            state_r <= TX_IDLE;
                        end
                    end
                end
                default: begin
                    ready_r <= 1'b0;
                    state_r <= TX_IDLE;
                end
            endcase
        end
    end

endmodule
